// File: rtl/delta_pkg.sv
// Shared helpers for the delta path: signed limits, overflow detection and the
// adder result record.
package delta_pkg;

    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Largest signed value representable in w bits, as a MAX_W-bit pattern.
    function automatic logic [MAX_W-1:0] smax(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative signed value in w bits; truncation to w bits gives 100..0.
    function automatic logic [MAX_W-1:0] smin(input int unsigned w);
        return ~smax(w);
    endfunction

    function automatic logic ovf_detect(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational two's complement adder with signed overflow flag and optional
// clamping to the signed range.
module sat_add
    import delta_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH:0] w_sum_ext;

    assign w_sum_ext = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    assign o_ovf     = ovf_detect(i_a[WIDTH-1], i_b[WIDTH-1], w_sum_ext[WIDTH-1]);

    // On overflow the extra sign bit holds the true sign, which picks the rail.
    always_comb begin
        o_sum = w_sum_ext[WIDTH-1:0];
        if (SATURATE && o_ovf) begin
            o_sum = w_sum_ext[WIDTH] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
        end
    end

endmodule

// File: rtl/delta_integrator.sv
// Rebuilds absolute samples from a signed delta stream (running sum), with a
// single-register valid/ready output stage.
module delta_integrator
    import delta_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_delta,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_ovf;
    logic             w_accept;

    sat_add #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (in_delta),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    // Output stage refills in the same cycle it drains.
    assign in_ready = !rst && !clear && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // The output register always mirrors the accumulator, so one register serves both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (clear) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            if (in_first) begin
                r_acc   <= in_delta;
                r_ovf   <= 1'b0;
                r_count <= CNT_W'(1);
            end else begin
                r_acc   <= w_add_sum;
                r_ovf   <= w_add_ovf;
                r_count <= (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_count = r_count;

endmodule
